// File: rtl/ibus_line_responder_pkg.sv
// Shared types and constants for the instruction-bus line responder.
//   ibus_req_t / ibus_resp_t : fetch-side request and response
//   cbus_req_t / cbus_resp_t : interconnect-side burst request and beat response
//   ibresp_state_t           : responder FSM encoding
package ibus_line_responder_pkg;

    localparam int IBUF_LINE_BEATS = 4;

    localparam logic [2:0] MSIZE8         = 3'd3;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IB_IDLE,
        IB_FILL,
        IB_RESP
    } ibresp_state_t;

endpackage

// File: rtl/ibus_line_buf.sv
// Single-line instruction buffer: LINE_BEATS x 64-bit storage, tag and valid.
//   clk, rst      : clock, asynchronous active-low reset (clears valid/tag)
//   wr_en/wr_idx/wr_data : beat write port used during refill
//   commit, commit_valid, commit_tag : end of refill, installs tag and validity
//   invalidate    : clears valid (ignored in a commit cycle)
//   lookup_addr   : word address of the fetch request (byte address bits 63:2)
//   hit           : valid and tag match for lookup_addr
//   rd_word       : 32-bit word selected by lookup_addr
module ibus_line_buf #(
    parameter  int LINE_BEATS = 4,
    localparam int OFS        = $clog2(LINE_BEATS * 8),
    localparam int IW         = $clog2(LINE_BEATS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [IW-1:0]   wr_idx,
    input  logic [63:0]     wr_data,
    input  logic            commit,
    input  logic            commit_valid,
    input  logic [63:OFS]   commit_tag,
    input  logic            invalidate,
    input  logic [63:2]     lookup_addr,
    output logic            hit,
    output logic [31:0]     rd_word
);

    logic [63:0]   mem [LINE_BEATS];
    logic          valid_q;
    logic [63:OFS] tag_q;
    logic [IW-1:0] beat_sel;
    logic [63:0]   beat_data;

    // Data storage carries no reset; beats a short burst never wrote stay stale.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else if (commit) begin
            valid_q <= commit_valid;
            tag_q   <= commit_tag;
        end else if (invalidate) begin
            valid_q <= 1'b0;
        end
    end

    assign hit       = valid_q && (tag_q == lookup_addr[63:OFS]);
    assign beat_sel  = lookup_addr[OFS-1:3];
    assign beat_data = mem[beat_sel];
    assign rd_word   = lookup_addr[2] ? beat_data[63:32] : beat_data[31:0];

endmodule

// File: rtl/ibus_line_responder.sv
// Instruction-bus responder with a one-line buffer refilled by an INCR burst.
//   clk, rst  : clock, asynchronous active-low reset
//   ibus_req  : fetch request {valid, addr}, held until served
//   ibus_resp : {addr_ok, data_ok, data}, one cycle per served request
//   flush     : one-cycle pulse invalidating the line buffer
//   creq      : burst read request toward the interconnect
//   cresp     : beat responses {ready, last, data}
//
// state   | meaning
// IB_IDLE | compare request against buffer, start refill on miss
// IB_FILL | burst outstanding, beats written as they arrive
// IB_RESP | single response cycle, word picked from current request address
module ibus_line_responder
    import ibus_line_responder_pkg::*;
#(
    parameter int LINE_BEATS = IBUF_LINE_BEATS
) (
    input  logic       clk,
    input  logic       rst,
    input  ibus_req_t  ibus_req,
    output ibus_resp_t ibus_resp,
    input  logic       flush,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);

    localparam int OFS = $clog2(LINE_BEATS * 8);
    localparam int IW  = $clog2(LINE_BEATS);

    ibresp_state_t state_q, state_d;
    logic [IW-1:0] cnt_q;
    logic [63:OFS] line_q;
    logic          flush_pend_q;

    logic          buf_hit;
    logic [31:0]   rd_word;
    logic          hit;
    logic          fill_start;
    logic          fill_done;
    logic          unused_addr_lsb;

    // A flush in the same cycle as a would-be hit forces a refill.
    assign hit        = ibus_req.valid && buf_hit && !flush;
    assign fill_start = (state_q == IB_IDLE) && ibus_req.valid && !hit;
    assign fill_done  = (state_q == IB_FILL) && cresp.ready && cresp.last;
    assign unused_addr_lsb = ^ibus_req.addr[1:0];

    ibus_line_buf #(
        .LINE_BEATS (LINE_BEATS)
    ) u_line_buf (
        .clk          (clk),
        .rst          (rst),
        .wr_en        ((state_q == IB_FILL) && cresp.ready),
        .wr_idx       (cnt_q),
        .wr_data      (cresp.data),
        .commit       (fill_done),
        .commit_valid (!(flush_pend_q || flush)),
        .commit_tag   (line_q),
        .invalidate   (flush || fill_start),
        .lookup_addr  (ibus_req.addr[63:2]),
        .hit          (buf_hit),
        .rd_word      (rd_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IB_IDLE;
            cnt_q        <= '0;
            line_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fill_start) begin
                cnt_q        <= '0;
                line_q       <= ibus_req.addr[63:OFS];
                flush_pend_q <= 1'b0;
            end else if (state_q == IB_FILL) begin
                if (cresp.ready) begin
                    cnt_q <= cnt_q + IW'(1);
                end
                if (fill_done) begin
                    flush_pend_q <= 1'b0;
                end else if (flush) begin
                    flush_pend_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ibus_resp = '0;
        creq      = '0;
        case (state_q)
            IB_IDLE: begin
                if (hit) begin
                    state_d = IB_RESP;
                end else if (ibus_req.valid) begin
                    state_d = IB_FILL;
                end
            end
            IB_FILL: begin
                creq.valid    = 1'b1;
                creq.is_write = 1'b0;
                creq.size     = MSIZE8;
                creq.addr     = {line_q, {OFS{1'b0}}};
                creq.len      = 8'(LINE_BEATS - 1);
                creq.burst    = AXI_BURST_INCR;
                // An early last is a protocol error; it still ends the fill.
                if (fill_done) begin
                    state_d = IB_IDLE;
                end
            end
            IB_RESP: begin
                ibus_resp.addr_ok = 1'b1;
                ibus_resp.data_ok = 1'b1;
                ibus_resp.data    = rd_word;
                state_d           = IB_IDLE;
            end
            default: begin
                state_d = IB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ibus_line_responder.sv
module tb_ibus_line_responder;
    import ibus_line_responder_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    ibus_req_t  ibus_req;
    ibus_resp_t ibus_resp;
    logic       flush;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int resp_cnt  = 0;
    int bad_order = 0;

    ibus_line_responder dut (
        .clk       (clk),
        .rst       (rst),
        .ibus_req  (ibus_req),
        .ibus_resp (ibus_resp),
        .flush     (flush),
        .creq      (creq),
        .cresp     (cresp)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ibus_resp.data_ok) resp_cnt++;
        if (ibus_resp.addr_ok !== ibus_resp.data_ok) bad_order++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Memory image: every 32-bit word holds its own address XOR 0x5A5A_0000.
    function automatic logic [31:0] wv(input logic [63:0] w);
        return w[31:0] ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [63:0] beat(input logic [63:0] b);
        return {wv(b + 64'd4), wv(b)};
    endfunction

    task automatic slot();
        @(negedge clk);
    endtask

    task automatic drive_req(input logic v, input logic [63:0] a);
        ibus_req.valid = v;
        ibus_req.addr  = a;
    endtask

    task automatic wait_creq(input int max, output int n, output logic [63:0] a, output logic [7:0] l);
        n = 0; a = '0; l = '0;
        for (int i = 1; i <= max; i++) begin
            slot();
            if (creq.valid) begin
                n = i; a = creq.addr; l = creq.len;
                break;
            end
        end
    endtask

    // Called in the first slot where creq.valid is seen; ev 1 = change addr, 2 = flush pulse,
    // applied together with beat ev_at+1.
    task automatic feed(input logic [63:0] line, input int nb, input int ev_at, input int ev,
                        input logic [63:0] ev_addr);
        for (int i = 0; i < nb; i++) begin
            flush = 1'b0;
            if (i == ev_at + 1 && ev == 1) ibus_req.addr = ev_addr;
            if (i == ev_at + 1 && ev == 2) flush = 1'b1;
            cresp.ready = 1'b1;
            cresp.last  = (i == nb - 1);
            cresp.data  = beat(line + 64'(i * 8));
            slot();
        end
        flush = 1'b0;
        cresp = '0;
    endtask

    task automatic wait_resp(input int max, output int n, output logic [31:0] d, output int creq_seen);
        n = 0; d = '0; creq_seen = 0;
        for (int i = 1; i <= max; i++) begin
            slot();
            if (creq.valid) creq_seen++;
            if (ibus_resp.data_ok) begin
                n = i; d = ibus_resp.data;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; cresp = '0; ibus_req = '0;
        #1 rst = 1'b0;
        slot();
        total_cnt++; if (creq.valid !== 1'b0) $display("FAIL rst_creq: got %b want 0", creq.valid); else pass_cnt++;
        total_cnt++; if (ibus_resp !== '0) $display("FAIL rst_resp: got %h want 0", ibus_resp); else pass_cnt++;
        rst = 1'b1;
        slot();
        total_cnt++; if (creq.valid !== 1'b0) $display("FAIL idle_creq: got %b want 0", creq.valid); else pass_cnt++;
    endtask

    task automatic test_cold_miss();
        int n, cs; logic [63:0] a; logic [7:0] l; logic [31:0] d;
        drive_req(1'b1, 64'h8000_0000);
        wait_creq(10, n, a, l);
        total_cnt++; if (n !== 1) $display("FAIL cold_creq_lat: got %0d want 1", n); else pass_cnt++;
        total_cnt++; if (a !== 64'h8000_0000) $display("FAIL cold_addr: got %h want 80000000", a); else pass_cnt++;
        total_cnt++; if (l !== 8'd3) $display("FAIL cold_len: got %0d want 3", l); else pass_cnt++;
        total_cnt++; if (creq.size !== MSIZE8 || creq.burst !== AXI_BURST_INCR || creq.is_write !== 1'b0)
            $display("FAIL cold_attr: got size %0d burst %0d wr %b", creq.size, creq.burst, creq.is_write); else pass_cnt++;
        feed(64'h8000_0000, 4, -1, 0, '0);
        total_cnt++; if (creq.valid !== 1'b0 || ibus_resp.data_ok !== 1'b0)
            $display("FAIL cold_after_last: got creq %b resp %b want 0 0", creq.valid, ibus_resp.data_ok); else pass_cnt++;
        wait_resp(10, n, d, cs);
        total_cnt++; if (n !== 1) $display("FAIL cold_resp_lat: got %0d want 1", n); else pass_cnt++;
        total_cnt++; if (d !== 32'hDA5A_0000) $display("FAIL cold_data: got %h want DA5A0000", d); else pass_cnt++;
        drive_req(1'b0, 64'h0);
        slot();
    endtask

    task automatic test_hit();
        int n, cs; logic [31:0] d;
        drive_req(1'b1, 64'h8000_001C);
        wait_resp(10, n, d, cs);
        total_cnt++; if (n !== 1) $display("FAIL hit_lat: got %0d want 1", n); else pass_cnt++;
        total_cnt++; if (d !== 32'hDA5A_001C) $display("FAIL hit_data_upper: got %h want DA5A001C", d); else pass_cnt++;
        total_cnt++; if (cs !== 0) $display("FAIL hit_no_creq: got %0d want 0", cs); else pass_cnt++;
        drive_req(1'b1, 64'h8000_0008);
        wait_resp(10, n, d, cs);
        total_cnt++; if (n !== 2) $display("FAIL b2b_lat: got %0d want 2", n); else pass_cnt++;
        total_cnt++; if (d !== 32'hDA5A_0008) $display("FAIL b2b_data: got %h want DA5A0008", d); else pass_cnt++;
        drive_req(1'b0, 64'h0);
        slot();
    endtask

    task automatic test_next_line();
        int n, cs; logic [63:0] a; logic [7:0] l; logic [31:0] d;
        drive_req(1'b1, 64'h8000_0020);
        wait_creq(10, n, a, l);
        total_cnt++; if (n !== 1 || a !== 64'h8000_0020) $display("FAIL next_addr: got %h lat %0d want 80000020 lat 1", a, n); else pass_cnt++;
        feed(64'h8000_0020, 4, -1, 0, '0);
        wait_resp(10, n, d, cs);
        total_cnt++; if (d !== 32'hDA5A_0020) $display("FAIL next_data: got %h want DA5A0020", d); else pass_cnt++;
        drive_req(1'b0, 64'h0);
        slot();
        drive_req(1'b1, 64'h8000_0000);
        wait_creq(10, n, a, l);
        total_cnt++; if (n !== 1 || a !== 64'h8000_0000) $display("FAIL remiss_addr: got %h lat %0d want 80000000 lat 1", a, n); else pass_cnt++;
        feed(64'h8000_0000, 4, -1, 0, '0);
        wait_resp(10, n, d, cs);
        total_cnt++; if (d !== 32'hDA5A_0000) $display("FAIL remiss_data: got %h want DA5A0000", d); else pass_cnt++;
        drive_req(1'b0, 64'h0);
        slot();
    endtask

    task automatic test_addr_change();
        int n, cs, rc0; logic [63:0] a; logic [7:0] l; logic [31:0] d;
        rc0 = resp_cnt;
        drive_req(1'b1, 64'h8000_0040);
        wait_creq(10, n, a, l);
        total_cnt++; if (a !== 64'h8000_0040) $display("FAIL chg_first_addr: got %h want 80000040", a); else pass_cnt++;
        feed(64'h8000_0040, 4, 1, 1, 64'h8000_0100);
        total_cnt++; if (ibus_resp.data_ok !== 1'b0) $display("FAIL chg_no_early_resp: got %b want 0", ibus_resp.data_ok); else pass_cnt++;
        wait_creq(10, n, a, l);
        total_cnt++; if (n !== 1 || a !== 64'h8000_0100) $display("FAIL chg_second_addr: got %h lat %0d want 80000100 lat 1", a, n); else pass_cnt++;
        feed(64'h8000_0100, 4, -1, 0, '0);
        wait_resp(10, n, d, cs);
        total_cnt++; if (n !== 1 || d !== 32'hDA5A_0100) $display("FAIL chg_data: got %h lat %0d want DA5A0100 lat 1", d, n); else pass_cnt++;
        drive_req(1'b0, 64'h0);
        slot();
        slot();
        total_cnt++; if (resp_cnt - rc0 !== 1) $display("FAIL chg_single_resp: got %0d want 1", resp_cnt - rc0); else pass_cnt++;
    endtask

    task automatic test_flush();
        int n, cs; logic [63:0] a; logic [7:0] l; logic [31:0] d;
        drive_req(1'b1, 64'h8000_0200);
        wait_creq(10, n, a, l);
        total_cnt++; if (a !== 64'h8000_0200) $display("FAIL fl_first_addr: got %h want 80000200", a); else pass_cnt++;
        feed(64'h8000_0200, 4, 1, 2, '0);
        wait_creq(10, n, a, l);
        total_cnt++; if (n !== 1 || a !== 64'h8000_0200) $display("FAIL fl_refetch: got %h lat %0d want 80000200 lat 1", a, n); else pass_cnt++;
        feed(64'h8000_0200, 4, -1, 0, '0);
        wait_resp(10, n, d, cs);
        total_cnt++; if (n !== 1 || d !== 32'hDA5A_0200) $display("FAIL fl_data: got %h lat %0d want DA5A0200 lat 1", d, n); else pass_cnt++;
        drive_req(1'b0, 64'h0);
        slot();
        drive_req(1'b1, 64'h8000_0208);
        flush = 1'b1;
        slot();
        flush = 1'b0;
        total_cnt++; if (creq.valid !== 1'b1 || creq.addr !== 64'h8000_0200 || ibus_resp.data_ok !== 1'b0)
            $display("FAIL fl_hit_same_cycle: got creq %b addr %h resp %b want 1 80000200 0", creq.valid, creq.addr, ibus_resp.data_ok);
        else pass_cnt++;
        feed(64'h8000_0200, 4, -1, 0, '0);
        wait_resp(10, n, d, cs);
        total_cnt++; if (d !== 32'hDA5A_0208) $display("FAIL fl_hit_data: got %h want DA5A0208", d); else pass_cnt++;
        drive_req(1'b0, 64'h0);
        slot();
    endtask

    task automatic test_async_reset();
        int n, cs; logic [63:0] a; logic [7:0] l; logic [31:0] d;
        drive_req(1'b1, 64'h8000_0300);
        wait_creq(10, n, a, l);
        total_cnt++; if (a !== 64'h8000_0300) $display("FAIL ar_first_addr: got %h want 80000300", a); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            cresp.ready = 1'b1;
            cresp.last  = 1'b0;
            cresp.data  = beat(64'h8000_0300 + 64'(i * 8));
            slot();
        end
        cresp = '0;
        #2 rst = 1'b0;
        #1;
        total_cnt++; if (creq.valid !== 1'b0 || ibus_resp !== '0)
            $display("FAIL ar_immediate: got creq %b resp %h want 0 0", creq.valid, ibus_resp); else pass_cnt++;
        slot();
        rst = 1'b1;
        wait_creq(10, n, a, l);
        total_cnt++; if (n !== 1 || a !== 64'h8000_0300 || l !== 8'd3)
            $display("FAIL ar_refill: got %h len %0d lat %0d want 80000300 len 3 lat 1", a, l, n); else pass_cnt++;
        feed(64'h8000_0300, 4, -1, 0, '0);
        wait_resp(10, n, d, cs);
        total_cnt++; if (n !== 1 || d !== 32'hDA5A_0300) $display("FAIL ar_data: got %h lat %0d want DA5A0300 lat 1", d, n); else pass_cnt++;
        drive_req(1'b0, 64'h0);
        slot();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_next_line();
        test_addr_change();
        test_flush();
        test_async_reset();
        total_cnt++; if (bad_order !== 0) $display("FAIL resp_ok_pairing: got %0d bad cycles want 0", bad_order); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
